// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control unit.
// Steps each instruction through fetch/decode/execute/memory/writeback states
// and drives the shared datapath enables and mux selects from the current state.
// Fetch and memory states wait on a req/ack memory handshake.
// Also provides an illegal-opcode trap and a counter of retired instructions.
// Optional build macro: MULTICYCLE_CTRL_BNE_EN adds BNE support and a bne port.
module multicycle_ctrl #(
  parameter int OP_W      = 6,
  parameter int CNT_W     = 32,
  parameter int TRAP_HALT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic             memwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             immzero,
  output logic [2:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
`ifdef MULTICYCLE_CTRL_BNE_EN
  output logic             bne,
`endif
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_ALUWB  = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BEQ    = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13,
    S_BNE    = 4'd14
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_XORI = OP_W'(6'b001110);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;

  // True for the I-type ALU opcodes that share the IEXEC/IWB path.
  function automatic logic is_imm_op(input logic [OP_W-1:0] o);
    return (o == OP_ADDI) || (o == OP_ANDI) || (o == OP_ORI) ||
           (o == OP_XORI) || (o == OP_LUI);
  endfunction

  // ALU operation for an I-type ALU opcode; anything else adds.
  function automatic logic [2:0] imm_aluop(input logic [OP_W-1:0] o);
    logic [2:0] r;
    r = ALU_ADD;
    if (o == OP_ANDI)      r = ALU_AND;
    else if (o == OP_ORI)  r = ALU_OR;
    else if (o == OP_XORI) r = ALU_XOR;
    else if (o == OP_LUI)  r = ALU_LUI;
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  // State register; reset aborts any instruction in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Opcode snapshot taken in DECODE so later states do not depend on the IR staying put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   op_q <= '0;
    else if (state_q == S_DECODE) op_q <= op;
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  // Next-state and Moore output decode; only irwrite/pcwrite/memwrite look at mem_ack.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    immzero  = 1'b0;
    aluop    = ALU_ADD;
    pcsrc    = 2'b00;
    trap     = 1'b0;
`ifdef MULTICYCLE_CTRL_BNE_EN
    bne      = 1'b0;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ack;
        pcwrite = mem_ack;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if ((op == OP_LW) || (op == OP_SW)) state_d = S_MEMADR;
        else if (op == OP_R)                state_d = S_REXEC;
        else if (is_imm_op(op))             state_d = S_IEXEC;
        else if (op == OP_BEQ)              state_d = S_BEQ;
        else if (op == OP_J)                state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_BNE_EN
        else if (op == OP_BNE)              state_d = S_BNE;
`endif
        else                                state_d = S_TRAP;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ack) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = mem_ack;
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = imm_aluop(op_q);
        immzero = (op_q == OP_ANDI) || (op_q == OP_ORI) ||
                  (op_q == OP_XORI) || (op_q == OP_LUI);
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_BNE_EN
      // Same datapath controls as BEQ; the datapath inverts zero when bne is set.
      S_BNE: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        branch  = 1'b1;
        bne     = 1'b1;
        pcsrc   = 2'b01;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
`endif
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
        if (TRAP_HALT == 0) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed test of the multicycle control unit.
// Main instance: CNT_W = 4, TRAP_HALT = 1. Second instance with TRAP_HALT = 0
// shares the inputs and is checked only for the trap-return behaviour.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                 ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_REXEC = 7,
                 ST_ALUWB = 8, ST_IEXEC = 9, ST_IWB = 10, ST_BEQ = 11,
                 ST_JUMP = 12, ST_TRAP = 13;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ack;

  logic mem_req, iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst;
  logic memtoreg, alusrca, immzero, trap;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] instret;
  logic [3:0] state_o;

  logic mem_req0, iord0, irwrite0, pcwrite0, branch0, memwrite0, regwrite0, regdst0;
  logic memtoreg0, alusrca0, immzero0, trap0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] aluop0;
  logic [31:0] instret0;
  logic [3:0] state0;
`ifdef MULTICYCLE_CTRL_BNE_EN
  logic bne, bne0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [18:0] outs_all;
  assign outs_all = {mem_req, iord, irwrite, pcwrite, branch, memwrite, regwrite,
                     regdst, memtoreg, alusrca, alusrcb, immzero, aluop, pcsrc, trap};

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(6), .CNT_W(4), .TRAP_HALT(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ack(mem_ack),
    .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .immzero(immzero),
    .aluop(aluop), .pcsrc(pcsrc), .trap(trap), .instret(instret),
`ifdef MULTICYCLE_CTRL_BNE_EN
    .bne(bne),
`endif
    .state_o(state_o)
  );

  multicycle_ctrl #(.OP_W(6), .CNT_W(32), .TRAP_HALT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ack(mem_ack),
    .mem_req(mem_req0), .iord(iord0), .irwrite(irwrite0), .pcwrite(pcwrite0),
    .branch(branch0), .memwrite(memwrite0), .regwrite(regwrite0), .regdst(regdst0),
    .memtoreg(memtoreg0), .alusrca(alusrca0), .alusrcb(alusrcb0), .immzero(immzero0),
    .aluop(aluop0), .pcsrc(pcsrc0), .trap(trap0), .instret(instret0),
`ifdef MULTICYCLE_CTRL_BNE_EN
    .bne(bne0),
`endif
    .state_o(state0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH with zero-wait memory, checking each state.
  task automatic run_simple(input logic [5:0] o, input int exec_st, input int wb_st,
                            input logic [3:0] ret_exp);
    op = o;
    tick(); chk("dec_state", state_o, ST_DECODE);
    tick(); chk("exec_state", state_o, exec_st);
    if (wb_st >= 0) begin
      tick(); chk("wb_state", state_o, wb_st);
    end
    tick(); chk("ret_fetch", state_o, ST_FETCH);
    chk("ret_instret", instret, ret_exp);
  endtask

  initial begin
    rst_n = 1'b0; op = OP_LW; mem_ack = 1'b1;

    // Reset state
    tick();
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_instret", instret, 0);
    chk("rst_outs", outs_all, 0);
    rst_n = 1'b1; #1;
    chk("idle_state", state_o, ST_IDLE);

    // LW, zero-wait: 5 cycles
    tick(); chk("lw_fetch", state_o, ST_FETCH);
    chk("lw_fetch_req", mem_req, 1); chk("lw_fetch_irw", irwrite, 1);
    chk("lw_fetch_alusrcb", alusrcb, 2'b01);
    tick(); chk("lw_decode", state_o, ST_DECODE); chk("lw_dec_alusrcb", alusrcb, 2'b11);
    chk("lw_dec_rw", regwrite, 0);
    tick(); chk("lw_memadr", state_o, ST_MEMADR); chk("lw_adr_srcb", alusrcb, 2'b10);
    chk("lw_adr_srca", alusrca, 1);
    tick(); chk("lw_memrd", state_o, ST_MEMRD); chk("lw_rd_iord", iord, 1);
    chk("lw_rd_rw", regwrite, 0);
    tick(); chk("lw_memwb", state_o, ST_MEMWB);
    chk("lw_wb_rw", regwrite, 1); chk("lw_wb_m2r", memtoreg, 1); chk("lw_wb_dst", regdst, 0);
    tick(); chk("lw_ret", state_o, ST_FETCH); chk("lw_instret", instret, 1);
    chk("lw_ret_rw", regwrite, 0);

    // R-type with three wait cycles in FETCH
    op = OP_R; mem_ack = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("r_wait_state", state_o, ST_FETCH);
      chk("r_wait_req", mem_req, 1);
      chk("r_wait_irw", irwrite, 0);
      chk("r_wait_pcw", pcwrite, 0);
      tick();
    end
    mem_ack = 1'b1; #1;
    chk("r_ack_state", state_o, ST_FETCH); chk("r_ack_req", mem_req, 1);
    chk("r_ack_irw", irwrite, 1); chk("r_ack_pcw", pcwrite, 1);
    tick(); chk("r_decode", state_o, ST_DECODE);
    tick(); chk("r_rexec", state_o, ST_REXEC); chk("r_aluop", aluop, 3'b010);
    chk("r_srcb", alusrcb, 2'b00); chk("r_srca", alusrca, 1);
    tick(); chk("r_aluwb", state_o, ST_ALUWB); chk("r_wb_dst", regdst, 1);
    chk("r_wb_rw", regwrite, 1);
    tick(); chk("r_ret", state_o, ST_FETCH); chk("r_instret", instret, 2);

    // ORI then ADDI
    op = OP_ORI;
    tick(); chk("ori_decode", state_o, ST_DECODE);
    tick(); chk("ori_iexec", state_o, ST_IEXEC); chk("ori_aluop", aluop, 3'b100);
    chk("ori_immzero", immzero, 1); chk("ori_srcb", alusrcb, 2'b10);
    tick(); chk("ori_iwb", state_o, ST_IWB); chk("ori_rw", regwrite, 1); chk("ori_dst", regdst, 0);
    tick(); chk("ori_ret", state_o, ST_FETCH); chk("ori_instret", instret, 3);
    op = OP_ADDI;
    tick(); chk("addi_decode", state_o, ST_DECODE);
    tick(); chk("addi_iexec", state_o, ST_IEXEC); chk("addi_aluop", aluop, 3'b000);
    chk("addi_immzero", immzero, 0);
    tick(); chk("addi_iwb", state_o, ST_IWB);
    tick(); chk("addi_instret", instret, 4);

    // SW (4 cycles) and J (3 cycles)
    op = OP_SW;
    tick(); tick(); chk("sw_memadr", state_o, ST_MEMADR);
    tick(); chk("sw_memwr", state_o, ST_MEMWR); chk("sw_memwrite", memwrite, 1);
    chk("sw_iord", iord, 1);
    tick(); chk("sw_ret", state_o, ST_FETCH); chk("sw_instret", instret, 5);
    op = OP_J;
    tick(); tick(); chk("j_state", state_o, ST_JUMP); chk("j_pcw", pcwrite, 1);
    chk("j_pcsrc", pcsrc, 2'b10);
    tick(); chk("j_ret", state_o, ST_FETCH); chk("j_instret", instret, 6);

    // Illegal opcode
    op = OP_BAD;
    tick(); chk("trap_decode", state_o, ST_DECODE);
    tick(); chk("trap_state", state_o, ST_TRAP); chk("trap_out", trap, 1);
    chk("trap0_state", state0, ST_TRAP); chk("trap0_out", trap0, 1);
    tick(); chk("trap0_back", state0, ST_FETCH); chk("trap0_clear", trap0, 0);
    chk("trap0_instret", instret0, 6);
    for (int i = 0; i < 10; i++) begin
      chk("trap_hold", trap, 1);
      chk("trap_hold_st", state_o, ST_TRAP);
      chk("trap_instret", instret, 6);
      tick();
    end

    // Reset aborting a stalled store
    rst_n = 1'b0; #1;
    chk("rst2_state", state_o, ST_IDLE);
    tick(); rst_n = 1'b1; op = OP_J; mem_ack = 1'b1;
    tick(); chk("rst2_fetch", state_o, ST_FETCH);
    tick(); tick(); tick(); chk("rst2_j_instret", instret, 1);
    op = OP_SW;
    tick(); tick(); chk("abort_memadr", state_o, ST_MEMADR);
    mem_ack = 1'b0;
    tick(); chk("abort_memwr", state_o, ST_MEMWR); chk("abort_req", mem_req, 1);
    chk("abort_mw_wait", memwrite, 0);
    tick(); chk("abort_memwr_hold", state_o, ST_MEMWR); chk("abort_req_hold", mem_req, 1);
    chk("abort_iord_hold", iord, 1);
    #2 rst_n = 1'b0; #1;
    chk("abort_outs", outs_all, 0);
    chk("abort_state", state_o, ST_IDLE);
    chk("abort_instret", instret, 0);
    tick(); chk("abort_mw_rst", memwrite, 0);
    rst_n = 1'b1; mem_ack = 1'b1; #1;
    chk("abort_idle", state_o, ST_IDLE); chk("abort_mw_idle", memwrite, 0);
    tick(); chk("abort_fetch", state_o, ST_FETCH); chk("abort_mw_fetch", memwrite, 0);

    // 16 BEQs on a 4-bit counter
    rst_n = 1'b0; #1;
    tick(); rst_n = 1'b1; op = OP_BEQ;
    tick(); chk("beq_fetch", state_o, ST_FETCH);
    for (int i = 1; i <= 16; i++) begin
      tick();
      tick();
      if (i == 1) begin
        chk("beq_state", state_o, ST_BEQ); chk("beq_branch", branch, 1);
        chk("beq_pcsrc", pcsrc, 2'b01); chk("beq_aluop", aluop, 3'b001);
        chk("beq_srca", alusrca, 1);
      end
      tick();
      chk("beq_ret", state_o, ST_FETCH);
      chk("beq_instret", instret, i % 16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
